vga_pic_gen: RTL and testbench

Pixel-colour generator directly downstream of the VGA timing controller. Consumes pix_x, pix_y, rgb_valid, hsync and vsync from that controller. Produces registered RGB565 with re-aligned syncs. Offers four selectable test patterns: colour bars, checkerboard, animated bouncing box, and grid. Mode and animation state change only once per frame, inside vertical sync, so an active frame never tears.

---
 rtl/vga_pic_gen.sv | 129 ++++++++++++
 tb/tb_vga_pic_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pic_gen.sv
// Test-pattern pixel generator that sits behind the VGA timing controller.
// It outputs registered RGB565 with syncs re-aligned; pattern and animation state change only inside vsync.
module vga_pic_gen #(
  parameter int          H_VALID   = 640,
  parameter int          V_VALID   = 480,
  parameter int          BOX_SIZE  = 64,
  parameter int          STEP      = 2,
  parameter logic [15:0] BOX_COLOR = 16'hF800,
  parameter int          CELL_LOG2 = 5
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        rgb_valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        mode_step,
  output logic [15:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [1:0]  mode,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_LIM  = 11'(H_VALID);
  localparam logic [10:0] V_LIM  = 11'(V_VALID);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BAR_W  = 11'(H_VALID / 8);
  localparam logic [15:0] BAR_COLORS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        vsync_d;
  logic        frame_tick;
  logic        step_pending;
  logic [10:0] box_x;
  logic [10:0] box_y;
  logic        dir_x;
  logic        dir_y;
  logic [11:0] next_x;
  logic [11:0] next_y;
  logic [10:0] px;
  logic [10:0] py;
  logic [15:0] colour;

  // Returns {direction, position}; direction 1 means moving towards the far edge.
  function automatic logic [11:0] next_pos(input logic [10:0] pos, input logic dir_pos,
                                           input logic [10:0] limit);
    logic [11:0] r;
    if (dir_pos) begin
      if (pos + BOX_W + STEP_W > limit) r = {1'b0, limit - BOX_W};
      else                              r = {1'b1, pos + STEP_W};
    end else begin
      if (pos < STEP_W) r = {1'b1, 11'd0};
      else              r = {1'b0, pos - STEP_W};
    end
    return r;
  endfunction

  assign frame_tick = vsync_in & ~vsync_d;
  assign next_x     = next_pos(box_x, dir_x, H_LIM);
  assign next_y     = next_pos(box_y, dir_y, V_LIM);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d      <= 1'b0;
      step_pending <= 1'b0;
      mode         <= 2'd0;
      frame_cnt    <= 8'd0;
      box_x        <= 11'd0;
      box_y        <= 11'd0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
    end else begin
      vsync_d <= vsync_in;
      if (frame_tick) begin
        frame_cnt      <= frame_cnt + 8'd1;
        {dir_x, box_x} <= next_x;
        {dir_y, box_y} <= next_y;
        if (step_pending | mode_step) mode <= mode + 2'd1;
        step_pending   <= 1'b0;
      end else if (mode_step) begin
        step_pending <= 1'b1;
      end
    end
  end

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  always_comb begin
    colour = 16'h0000;
    case (mode)
      2'd0: begin
        // Last bar whose left edge has been passed wins, so no divider is needed.
        for (int i = 0; i < 8; i++) begin
          if (px >= 11'(i) * BAR_W) colour = BAR_COLORS[i];
        end
      end
      2'd1: begin
        if (pix_x[CELL_LOG2] ^ pix_y[CELL_LOG2]) colour = 16'hFFFF;
      end
      2'd2: begin
        if (px >= box_x && px < box_x + BOX_W && py >= box_y && py < box_y + BOX_W)
          colour = BOX_COLOR;
      end
      default: begin
        if (pix_x[CELL_LOG2-1:0] == '0 || pix_y[CELL_LOG2-1:0] == '0 ||
            px == H_LIM - 11'd1 || py == V_LIM - 11'd1)
          colour = 16'hFFFF;
      end
    endcase
  end

  // Output stage: one register shared by pixel and syncs keeps them aligned.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_out   <= 16'h0000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_out   <= rgb_valid ? colour : 16'h0000;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vga_pic_gen.sv
// Bench for vga_pic_gen: drives short synthetic frames and scoreboards every output cycle.
module tb_vga_pic_gen;

  typedef struct packed {
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic [1:0]  md;
    logic [7:0]  fc;
  } out_t;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        rgb_valid = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        mode_step = 1'b0;
  logic [15:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [1:0]  mode;
  logic [7:0]  frame_cnt;

  int   vecs = 0;
  int   fails = 0;
  out_t exp_q[$];
  out_t obs_q[$];

  // reference model state
  int m_mode, m_fc, m_bx, m_by;
  bit m_dx, m_dy, m_pend, m_vsd;

  vga_pic_gen dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .rgb_valid(rgb_valid), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_step(mode_step),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .mode(mode),
    .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] bar_colour(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_colour(input int x, input int y);
    case (m_mode)
      0: return bar_colour((x / 80 > 7) ? 7 : x / 80);
      1: return ((((x >> 5) & 1) ^ ((y >> 5) & 1)) != 0) ? 16'hFFFF : 16'h0000;
      2: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ? 16'hF800 : 16'h0000;
      default: return ((x % 32) == 0 || (y % 32) == 0 || x == 639 || y == 479) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0;
    m_dx = 1; m_dy = 1; m_pend = 0; m_vsd = 0;
  endtask

  // Drive one cycle, push the expected outputs, capture the observed outputs after the edge.
  task automatic step(input int x, input int y, input bit v, input bit hs, input bit vs, input bit ms);
    out_t e;
    bit   tick;
    pix_x = 10'(x); pix_y = 10'(y); rgb_valid = v;
    hsync_in = hs; vsync_in = vs; mode_step = ms;
    e.rgb = v ? model_colour(x, y) : 16'h0000;
    e.hs  = hs;
    e.vs  = vs;
    tick  = vs && !m_vsd;
    m_vsd = vs;
    if (tick) begin
      m_fc = (m_fc + 1) % 256;
      if (m_pend || ms) m_mode = (m_mode + 1) % 4;
      m_pend = 0;
      if (m_dx) begin
        if (m_bx + 64 + 2 > 640) begin m_bx = 576; m_dx = 0; end else m_bx += 2;
      end else begin
        if (m_bx < 2) begin m_bx = 0; m_dx = 1; end else m_bx -= 2;
      end
      if (m_dy) begin
        if (m_by + 64 + 2 > 480) begin m_by = 416; m_dy = 0; end else m_by += 2;
      end else begin
        if (m_by < 2) begin m_by = 0; m_dy = 1; end else m_by -= 2;
      end
    end else if (ms) begin
      m_pend = 1;
    end
    e.md = 2'(m_mode);
    e.fc = 8'(m_fc);
    exp_q.push_back(e);
    @(posedge vga_clk);
    #1;
    obs_q.push_back({rgb_out, hsync_out, vsync_out, mode, frame_cnt});
    mode_step = 1'b0;
  endtask

  task automatic vblank(input bit ms);
    step(0, 0, 0, 0, 1, ms);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    pix_x = '0; pix_y = '0; rgb_valid = 0; hsync_in = 0; vsync_in = 0; mode_step = 0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_t e, o;
    do_reset();
    vecs++;
    if ({rgb_out, hsync_out, vsync_out, mode, frame_cnt} !== 28'd0) begin
      fails++;
      $display("FAIL reset_state: got %h, want 0", {rgb_out, hsync_out, vsync_out, mode, frame_cnt});
    end
    step(0, 0, 0, 1, 0, 0);
    step(5, 5, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_idle: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  task automatic test_bars();
    out_t e, o;
    int   xs[12] = '{0, 79, 80, 159, 160, 240, 320, 400, 480, 559, 560, 639};
    do_reset();
    vblank(0);
    step(100, 10, 0, 1, 0, 0);
    step(300, 10, 0, 1, 0, 0);
    foreach (xs[i]) step(xs[i], 10, 1, 0, 0, 0);
    step(639, 10, 0, 1, 0, 0);
    step(0, 11, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL bars: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  task automatic test_mode_step();
    out_t e, o;
    do_reset();
    vblank(0);
    step(10, 20, 1, 0, 0, 1);
    step(11, 20, 1, 0, 0, 0);
    step(90, 20, 1, 0, 0, 1);
    step(170, 20, 1, 0, 0, 1);
    step(250, 20, 1, 0, 0, 0);
    vblank(0);
    step(32, 0, 1, 0, 0, 0);
    step(32, 32, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(31, 0, 1, 0, 0, 0);
    step(0, 32, 1, 0, 0, 0);
    vblank(0);
    step(32, 0, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL mode_step: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  task automatic test_step_at_tick();
    out_t e, o;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      vblank(f < 4);
      step(32, 0, 1, 0, 0, 0);
      step(100, 479, 1, 0, 0, 0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL step_at_tick: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  task automatic test_box();
    out_t e, o;
    do_reset();
    for (int t = 1; t <= 290; t++) begin
      vblank(t <= 2);
      if (t == 2 || t == 100 || (t >= 207 && t <= 211) || (t >= 287 && t <= 290)) begin
        step(m_bx, m_by, 1, 0, 0, 0);
        step(m_bx + 63, m_by + 63, 1, 0, 0, 0);
        step(m_bx + 64, m_by, 1, 0, 0, 0);
        step(m_bx, m_by + 64, 1, 0, 0, 0);
        if (m_bx > 0) step(m_bx - 1, m_by, 1, 0, 0, 0);
        if (m_by > 0) step(m_bx, m_by - 1, 1, 0, 0, 0);
        step(m_bx, m_by, 0, 1, 0, 0);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
        if (o !== e) begin
          fails++;
          $display("FAIL box t=%0d: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                   t, o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
        end
      end
    end
  endtask

  task automatic test_grid();
    out_t e, o;
    do_reset();
    repeat (3) vblank(1);
    step(0, 5, 1, 0, 0, 0);
    step(5, 5, 1, 0, 0, 0);
    step(639, 100, 1, 0, 0, 0);
    step(100, 479, 1, 0, 0, 0);
    step(64, 7, 1, 0, 0, 0);
    step(7, 96, 1, 0, 0, 0);
    step(638, 478, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL grid: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  task automatic test_mid_reset();
    out_t e, o;
    do_reset();
    for (int t = 1; t <= 300; t++) vblank(t <= 2);
    step(m_bx, m_by, 1, 1, 0, 0);
    step(m_bx + 1, m_by, 1, 1, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL pre_reset: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
    // assert reset away from the clock edge while an active pixel is on the inputs
    pix_x = 10'(m_bx + 2); pix_y = 10'(m_by); rgb_valid = 1; hsync_in = 1; vsync_in = 1;
    sys_rst_n = 1'b0;
    #1;
    vecs++;
    if (rgb_out !== 16'h0000) begin fails++; $display("FAIL mid_reset_rgb: got %h, want 0000", rgb_out); end
    vecs++;
    if ({hsync_out, vsync_out} !== 2'b00) begin fails++; $display("FAIL mid_reset_sync: got %b, want 00", {hsync_out, vsync_out}); end
    vecs++;
    if (mode !== 2'd0) begin fails++; $display("FAIL mid_reset_mode: got %0d, want 0", mode); end
    vecs++;
    if (frame_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset_fc: got %0d, want 0", frame_cnt); end
    do_reset();
    vblank(0);
    vblank(1);
    vblank(1);
    step(m_bx, m_by, 1, 0, 0, 0);
    step(m_bx - 1, m_by, 1, 0, 0, 0);
    step(m_bx + 64, m_by, 1, 0, 0, 0);
    step(m_bx, m_by - 1, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL post_reset: got rgb=%h hs=%b vs=%b mode=%0d fc=%0d, want rgb=%h hs=%b vs=%b mode=%0d fc=%0d",
                 o.rgb, o.hs, o.vs, o.md, o.fc, e.rgb, e.hs, e.vs, e.md, e.fc);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bars();
    test_mode_step();
    test_step_at_tick();
    test_box();
    test_grid();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
